keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment driver. Where the driver strobes digit enables outward, this block strobes the columns of a 4x4 matrix keypad and reads the rows back.
- It debounces each press and emits one 4-bit hex key code with a single-cycle valid pulse.
- Feeds the clock's time-set and control logic.
- Uses the same active-low strobe convention and the same divided scan tick style as the display path.

Parameters:
- SCAN_DIV_W, 13: scan tick fires once every 2^SCAN_DIV_W clk cycles.
- DEBOUNCE_CNT, 4: number of consecutive agreeing ticks needed to accept a press or a release (legal range 1..15).
- REPEAT_DELAY, 64: ticks from press acceptance to the first auto-repeat (KEY_REPEAT_EN only).
- REPEAT_RATE, 16: ticks between subsequent auto-repeats (KEY_REPEAT_EN only).

Ports:
- clk, input, 1: system clock.
- clr, input, 1: reset, synchronous to clk, active-high.
- row, input, 4: keypad rows, active-low, externally pulled up, asynchronous to clk.
- col, output, 4: column strobes, active-low; exactly one bit is low at any time.
- key, output, 4: hex code of the last accepted key.
- key_valid, output, 1: one-cycle pulse when key is updated.
- key_held, output, 1: high while the accepted key is still pressed.

Behaviour:
- Reset (clr=1 at a clk edge; clr wins over any tick or state action):
  - col=4'b1110, col_idx=0, state=SCAN.
  - key=0, key_valid=0, key_held=0.
  - prescaler=0, debounce counter=0, captured row=0.
- Row input: two-flop synchronizer. Internally rs = ~row_sync, so 1 means pressed.
- Tick: prescaler is SCAN_DIV_W bits and free-running. tick=1 for the one cycle in which the prescaler equals all-ones. All state actions occur only on tick cycles, except key_valid clearing.
- col drive: col[i]=0 iff col_idx==i. A column change takes effect the cycle after the tick, giving a full tick period of settling before the next sample.
- Row priority: when several rows read pressed, the lowest-index row wins (row_idx).
- States:
  - SCAN, on tick:
    - rs==0: col_idx advances 0→1→2→3→0.
    - otherwise: capture row_idx, hold col_idx, cnt=1, go to DEBOUNCE.
    - If DEBOUNCE_CNT==1, accept immediately (behave as on acceptance below).
  - DEBOUNCE, on tick:
    - rs still has bit row_idx set: cnt++.
    - else: go to SCAN and advance col_idx.
    - When cnt reaches DEBOUNCE_CNT, accept:
      - key ← KEYMAP[row_idx][col_idx]
      - key_valid=1 for exactly one clk
      - key_held=1
      - cnt=0, go to HELD.
  - HELD, on tick:
    - bit row_idx clear: cnt++.
    - bit set: cnt=0.
    - At DEBOUNCE_CNT: key_held=0, go to SCAN and advance col_idx.
    - key keeps its value.
    - Other keys pressed while HELD are ignored.
- KEYMAP (row,col):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E(*) 0 F(#) D
- Boundaries:
  - Bounce shorter than DEBOUNCE_CNT ticks produces no pulse.
  - A press on another column during DEBOUNCE is invisible because the column is held.
  - Counters saturate; they do not wrap.
  - Minimum latency from a stable press, when its column is already active: DEBOUNCE_CNT ticks plus 3 clk (synchronizer plus register).

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - A repeat counter runs in HELD while the key remains pressed.
  - REPEAT_DELAY ticks after acceptance, key_valid pulses again with the same key, then every REPEAT_RATE ticks.
  - Any release tick resets the repeat counter.
- Undefined: exactly one key_valid per accepted press; no repeat logic is synthesized.

Decomposition:
- Package keypad_pkg holds:
  - state enum {SCAN, DEBOUNCE, HELD}
  - the KEYMAP constant 4x4x4
  - ROWS=4, COLS=4
- Sub-module keypad_tick_gen (parameter SCAN_DIV_W; ports clk, clr, tick). It is shared with future scan-rate users.
- Synchronizer and FSM stay in keypad_scanner.

Test Plan:
All scenarios use SCAN_DIV_W=2 and DEBOUNCE_CNT=3, with a bench keypad model that pulls a row low when the active column matches the pressed key.

1. Reset: hold clr 3 cycles → col=1110, key=0, key_valid=0, key_held=0. With no keys, col steps 1110→1101→1011→0111→1110 once per 4 clk.
2. Press '5' (r1,c1) held steady → exactly one key_valid pulse with key=4'h5 and key_held=1. Release for 3+ ticks → key_held=0 and scanning resumes.
3. Bounce: press '9' for 2 ticks then release, repeated 5 times → no key_valid. A final stable press → a single pulse with key=4'h9.
4. Multi-key: press '*' (r3,c0) and '1' (r0,c0) together → key=4'h1. Press '#' while '1' is HELD → ignored, no pulse.
5. Reset mid-operation: assert clr during DEBOUNCE of 'D' → outputs return to reset values the next cycle, no pulse. After clr drops with 'D' still pressed → normal acceptance, key=4'hD.
6. With KEY_REPEAT_EN, REPEAT_DELAY=4, REPEAT_RATE=2: hold '0' → pulses on the acceptance tick, then +4 ticks, +6, +8, all with key=4'h0. Without the macro → exactly one pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, sizes and key map for the matrix keypad scanner
// Contents: ROWS/COLS matrix size, scanner state enum, KEYMAP[row][col] hex codes,
//           first_row() lowest-index pressed row picker.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_e;

  // Row r, column c -> hex code. '*' maps to E and '#' maps to F.
  localparam logic [3:0] KEYMAP [ROWS][COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Lowest-index set bit wins when several rows read pressed.
  function automatic logic [1:0] first_row(input logic [ROWS-1:0] rs);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (rs[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// rtl/keypad_tick_gen.sv - free-running prescaler producing a one-cycle scan tick
// Ports:
//   clk  - system clock
//   clr  - synchronous active-high reset
//   tick - high for one clk every 2^SCAN_DIV_W cycles (prescaler all-ones)
module keypad_tick_gen #(
  parameter int SCAN_DIV_W = 13
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  logic [SCAN_DIV_W-1:0] presc_q;
  logic [SCAN_DIV_W-1:0] presc_d;

  assign presc_d = presc_q + SCAN_DIV_W'(1);
  assign tick    = &presc_q;

  always_ff @(posedge clk) begin
    if (clr) presc_q <= '0;
    else     presc_q <= presc_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and hex key output
// Ports:
//   clk       - system clock
//   clr       - synchronous active-high reset
//   row       - keypad rows, active-low, asynchronous to clk
//   col       - column strobes, active-low, exactly one low
//   key       - hex code of the last accepted key
//   key_valid - one-cycle pulse when key is updated
//   key_held  - high while the accepted key stays pressed
// Optional: define KEY_REPEAT_EN to add auto-repeat pulses while a key is held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W   = 13,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE  = 16
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [3:0]      key,
  output logic            key_valid,
  output logic            key_held
);

  localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_CNT);

  logic tick;

  keypad_tick_gen #(.SCAN_DIV_W(SCAN_DIV_W)) u_tick_gen (
    .clk  (clk),
    .clr  (clr),
    .tick (tick)
  );

  // Two-flop synchronizer; idle value is all-ones (rows pulled up).
  logic [ROWS-1:0] row_s1_q;
  logic [ROWS-1:0] row_s2_q;
  logic [ROWS-1:0] rs;

  always_ff @(posedge clk) begin
    if (clr) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
    end
  end

  assign rs = ~row_s2_q;

  state_e     state_q, state_d;
  logic [1:0] col_idx_q, col_idx_d;
  logic [1:0] row_idx_q, row_idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_inc;
  logic [3:0] key_q, key_d;
  logic       valid_q, valid_d;
  logic       held_q, held_d;
  logic       accept;
  logic       row_hit;
  logic       rpt_fire;

  assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  assign row_hit = rs[row_idx_q];

`ifdef KEY_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_DELAY + REPEAT_RATE);

  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc;

  assign rpt_inc = rpt_q + RPT_W'(1);

  // Counts pressed ticks in HELD; after each repeat it restarts at RPT_FIRST so
  // the next one lands REPEAT_RATE ticks later. Outside HELD it sits at zero,
  // so it is already clear on the acceptance tick.
  always_comb begin
    rpt_d    = rpt_q;
    rpt_fire = 1'b0;
    if (state_q != HELD) begin
      rpt_d = '0;
    end else if (tick) begin
      if (!row_hit) begin
        rpt_d = '0;
      end else begin
        rpt_d = rpt_inc;
        if (rpt_inc == RPT_FIRST) begin
          rpt_fire = 1'b1;
        end else if (rpt_inc == RPT_NEXT) begin
          rpt_fire = 1'b1;
          rpt_d    = RPT_FIRST;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) rpt_q <= '0;
    else     rpt_q <= rpt_d;
  end
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = (REPEAT_DELAY > 0) && (REPEAT_RATE > 0);
  assign rpt_fire       = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    valid_d   = rpt_fire;
    held_d    = held_q;
    accept    = 1'b0;

    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (rs == '0) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_idx_d = first_row(rs);
            cnt_d     = 4'd1;
            state_d   = DEBOUNCE;
            accept    = (DB_TARGET == 4'd1);
          end
        end
        DEBOUNCE: begin
          if (row_hit) begin
            cnt_d  = cnt_inc;
            accept = (cnt_inc >= DB_TARGET);
          end else begin
            cnt_d     = 4'd0;
            state_d   = SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        HELD: begin
          // Only the captured row is watched; other keys cannot disturb it.
          cnt_d = row_hit ? 4'd0 : cnt_inc;
          if (!row_hit && (cnt_inc >= DB_TARGET)) begin
            held_d    = 1'b0;
            cnt_d     = 4'd0;
            state_d   = SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        default: state_d = SCAN;
      endcase
    end

    if (accept) begin
      key_d   = KEYMAP[row_idx_d][col_idx_q];
      valid_d = 1'b1;
      held_d  = 1'b1;
      cnt_d   = 4'd0;
      state_d = HELD;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= SCAN;
      col_idx_q <= 2'd0;
      row_idx_q <= 2'd0;
      cnt_q     <= 4'd0;
      key_q     <= 4'd0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  // Column decode from the registered index: changes the cycle after a tick.
  assign col       = ~(COLS'(1) << col_idx_q);
  assign key       = key_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV_W   (2),
    .DEBOUNCE_CNT (3),
    .REPEAT_DELAY (4),
    .REPEAT_RATE  (2)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Keypad model: a pressed key at (r,c) pulls row r low while column c is strobed.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  typedef struct {
    logic [3:0] key;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   last_pulse = 0;
  int   pulse_cnt = 0;
  int   mark;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic push_exp(input logic [3:0] k, input int g);
    exp_t e;
    e.key = k;
    e.gap = g;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per key_valid pulse.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pulse: actual key=%0h required no pulse", key);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_key", key, mon_e.key);
        check("pulse_held", key_held, 1);
        if (mon_e.gap != 0) check("pulse_gap", cyc - last_pulse, mon_e.gap);
      end
      last_pulse = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge right after col switches to target.
  task automatic wait_col_edge(input logic [3:0] target);
    logic [3:0] prev;
    bit ok;
    ok   = 1'b0;
    prev = col;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      if (col == target && prev != target) ok = 1'b1;
      prev = col;
    end
    if (!ok) begin
      checks++;
      $display("FAIL col_timeout: actual col=%b required %b within 80 cycles", col, target);
    end
  endtask

  task automatic wait_pulse();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 120 && !ok; i++) begin
      @(negedge clk);
      if (key_valid) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      $display("FAIL pulse_timeout: actual no key_valid required one within 120 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual time limit reached required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ec;
    logic [3:0] seen;

    // 1. Reset and idle scan
    clr     = 1'b1;
    pressed = 16'h0;
    step(3);
    check("rst_col", col, 4'b1110);
    check("rst_key", key, 4'h0);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    clr = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      ec = ~(4'b0001 << ((k / 4) % 4));
      check("scan_col", col, ec);
    end

    // 2. Press '5' (r1,c1) steadily, then release
    wait_col_edge(4'b1101);
    pressed[1*4+1] = 1'b1;
    push_exp(4'h5, 0);
    step(40);
    check("k5_key", key, 4'h5);
    check("k5_held", key_held, 1);
    pressed = 16'h0;
    step(30);
    check("k5_release", key_held, 0);
    check("k5_sb_empty", exp_q.size(), 0);
    seen = 4'h0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      seen = seen | ~col;
    end
    check("k5_rescan", seen, 4'hF);

    // 3. Bounce on '9' (r2,c2): two-tick presses never accepted
    mark = pulse_cnt;
    for (int n = 0; n < 5; n++) begin
      wait_col_edge(4'b1011);
      pressed[2*4+2] = 1'b1;
      step(8);
      pressed = 16'h0;
      step(8);
    end
    check("bounce_pulses", pulse_cnt - mark, 0);
    check("bounce_held", key_held, 0);
    wait_col_edge(4'b1011);
    pressed[2*4+2] = 1'b1;
    push_exp(4'h9, 0);
    step(40);
    check("k9_key", key, 4'h9);
    pressed = 16'h0;
    step(30);
    check("k9_release", key_held, 0);
    check("k9_sb_empty", exp_q.size(), 0);

    // 4. '*' and '1' together -> '1'; '#' while held ignored
    wait_col_edge(4'b1110);
    pressed[3*4+0] = 1'b1;
    pressed[0*4+0] = 1'b1;
    push_exp(4'h1, 0);
    step(40);
    check("multi_key", key, 4'h1);
    check("multi_held", key_held, 1);
    mark = pulse_cnt;
    pressed[3*4+2] = 1'b1;
    step(40);
    check("hash_ignored", pulse_cnt - mark, 0);
    check("hash_key", key, 4'h1);
    check("hash_held", key_held, 1);
    pressed = 16'h0;
    step(30);
    check("multi_release", key_held, 0);
    check("multi_sb_empty", exp_q.size(), 0);

    // 5. Reset during DEBOUNCE of 'D' (r3,c3)
    wait_col_edge(4'b0111);
    pressed[3*4+3] = 1'b1;
    step(5);
    clr = 1'b1;
    step(1);
    check("midrst_col", col, 4'b1110);
    check("midrst_key", key, 4'h0);
    check("midrst_valid", key_valid, 0);
    check("midrst_held", key_held, 0);
    clr = 1'b0;
    push_exp(4'hD, 0);
    step(60);
    check("kd_key", key, 4'hD);
    check("kd_held", key_held, 1);
    pressed = 16'h0;
    step(30);
    check("kd_release", key_held, 0);
    check("kd_sb_empty", exp_q.size(), 0);

    // 6. Hold '0' (r3,c1): auto-repeat when enabled, single pulse otherwise
    mark = pulse_cnt;
    wait_col_edge(4'b1101);
    pressed[3*4+1] = 1'b1;
    push_exp(4'h0, 0);
`ifdef KEY_REPEAT_EN
    push_exp(4'h0, 16);
    push_exp(4'h0, 8);
    push_exp(4'h0, 8);
`endif
    wait_pulse();
    step(34);
    pressed = 16'h0;
    step(30);
`ifdef KEY_REPEAT_EN
    check("k0_pulses", pulse_cnt - mark, 4);
`else
    check("k0_pulses", pulse_cnt - mark, 1);
`endif
    check("k0_key", key, 4'h0);
    check("k0_release", key_held, 0);
    check("k0_sb_empty", exp_q.size(), 0);

    step(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
